mul_div_unit: RTL
=================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter ITERS, default 32, number of iteration cycles per operation; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only when not busy.
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port src_a  input  32  multiplicand or dividend.
REQ-007 SHALL have port src_b  input  32  multiplier or divisor.
REQ-008 SHALL have port cancel  input  1  abort the in-flight operation (pipeline flush / exception).
REQ-009 SHALL have port busy  output  1  operation in progress; the pipeline stalls HI/LO readers while high.
REQ-010 SHALL have port HI_in  output  32  HI write data, carried to the HI/LO register file.
REQ-011 SHALL have port LO_in  output  32  LO write data.
REQ-012 SHALL have port HILO_Write  output  2  write enables: bit1 writes HI, bit0 writes LO.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-014 SHALL, in IDLE or DONE with start=1, latch op and the operand magnitudes, clear the iteration counter, and enter CALC on the next cycle.
REQ-015 SHALL, in CALC, perform one shift-add (multiply) or restoring-subtract (divide) step per cycle, and move to DONE after exactly 32 CALC cycles.
REQ-016 SHALL hold HILO_Write=2'b11 and drive final HI_in/LO_in in DONE for exactly one cycle, then return to IDLE unless a new start is accepted; start-to-write latency is 33 cycles.
REQ-017 SHALL drive busy=1 in CALC only, and busy=0 in IDLE and DONE.
REQ-018 SHALL drive HILO_Write=2'b00 in every state other than DONE; HI_in/LO_in hold the last result otherwise.
REQ-019 SHALL ignore start while in CALC, with no effect on the running operation.
REQ-020 SHALL, for MULT/MULTU, produce the 64-bit product with HI={product[63:32]} and LO={product[31:0]}; MULT is two's-complement signed, MULTU unsigned.
REQ-021 SHALL, for DIV/DIVU, produce LO=quotient and HI=remainder; DIV truncates toward zero, and the remainder takes the sign of the dividend.
REQ-022 SHALL, for src_b=0 (DIV or DIVU), produce LO=32'hFFFFFFFF and HI=src_a, raising no exception.
REQ-023 SHALL, for DIV with 32'h80000000 / 32'hFFFFFFFF, produce LO=32'h80000000 and HI=32'h0.
REQ-024 SHALL, on cancel=1 in CALC, return to IDLE on the next cycle with no HILO_Write pulse.
REQ-025 SHALL suppress the HILO_Write pulse on cancel=1 in DONE (HILO_Write forced 2'b00 that cycle).
REQ-026 SHALL give cancel priority over start when both are high in the same cycle: nothing is started.

Reset
REQ-027 SHALL, on rst=1 at posedge, enter IDLE and clear the counter, HI_in, LO_in, busy and HILO_Write to 0, including mid-operation.
REQ-028 SHALL give rst priority over start and cancel.

Structure
REQ-029 SHALL place the op encodings (OP_MULT..OP_DIVU) and the state encodings in shared package mul_div_pkg.
REQ-030 SHALL compute sign fix-up (negation of magnitudes and results) in the top module; one sub-module, div_restore_step, is natural for the combinational single-step subtract/shift.

Verification
REQ-031 SHALL cover MULT src_a=32'hFFFFFFFE (-2), src_b=3 -> after 33 cycles HILO_Write=11, HI=FFFFFFFF, LO=FFFFFFFA.
REQ-032 SHALL cover MULTU FFFFFFFF*FFFFFFFF -> HI=FFFFFFFE, LO=00000001; busy high exactly 32 cycles.
REQ-033 SHALL cover DIV -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU 7/0 -> LO=FFFFFFFF, HI=00000007.
REQ-034 SHALL cover DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
REQ-035 SHALL cover start DIVU, then cancel at CALC cycle 10 -> IDLE next cycle, no HILO_Write pulse; a new start is accepted immediately after.
REQ-036 SHALL cover rst asserted at CALC cycle 20 -> all outputs 0 next cycle and no write; start in the DONE cycle -> back-to-back results 33 cycles apart.

Source files
------------

// File: rtl/mul_div_pkg.sv
// rtl/mul_div_pkg.sv - shared op and state encodings for the iterative mul/div unit
package mul_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  // Magnitude of a 32-bit operand, treating it as signed only when requested.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one combinational restoring-division step on unsigned magnitudes
module div_restore_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted;
  logic        fits;

  // The partial remainder is always below the divisor, so the 33-bit shifted value
  // only ever needs 32 bits once the trial subtraction has been resolved.
  always_comb begin
    shifted = {rem_i, quo_i[31]};
    fits    = (shifted >= {1'b0, divisor_i});
    rem_o   = fits ? 32'(shifted - {1'b0, divisor_i}) : shifted[31:0];
    quo_o   = {quo_i[30:0], fits};
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32-cycle MULT/MULTU/DIV/DIVU unit writing HI/LO
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int unsigned ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] HI_in,
  output logic [31:0] LO_in,
  output logic [1:0]  HILO_Write
);

  localparam int unsigned      CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(ITERS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic [31:0]      mcand_q, mcand_d;
  logic [31:0]      acc_hi_q, acc_hi_d;
  logic [31:0]      acc_lo_q, acc_lo_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic             signed_op;
  logic [32:0]      mul_sum;
  logic [31:0]      div_rem, div_quo;
  logic [31:0]      step_hi, step_lo;
  logic [63:0]      prod_fix;
  logic [31:0]      quo_fix, rem_fix;

  div_restore_step u_div_step (
    .rem_i     (acc_hi_q),
    .quo_i     (acc_lo_q),
    .divisor_i (mcand_q),
    .rem_o     (div_rem),
    .quo_o     (div_quo)
  );

  // Datapath: {acc_hi, acc_lo} is the shifting product or the remainder/quotient pair.
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : 33'd0);
    step_hi   = op_q[1] ? div_rem : mul_sum[32:1];
    step_lo   = op_q[1] ? div_quo : {mul_sum[0], acc_lo_q[31:1]};
    prod_fix  = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    quo_fix   = div0_q ? 32'hFFFF_FFFF : (neg_q ? -step_lo : step_lo);
    rem_fix   = neg_rem_q ? -step_hi : step_hi;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE, DONE: begin
        if (cancel || !start) begin
          state_d = IDLE;
        end else begin
          state_d   = CALC;
          cnt_d     = '0;
          op_d      = op_e'(op);
          neg_d     = signed_op && (src_a[31] ^ src_b[31]);
          neg_rem_d = (op == OP_DIV) && src_a[31];
          div0_d    = (src_b == 32'd0);
          mcand_d   = mag32(src_b, signed_op);
          acc_hi_d  = '0;
          acc_lo_d  = mag32(src_a, signed_op);
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = DONE;
            hi_d    = op_q[1] ? rem_fix : prod_fix[63:32];
            lo_d    = op_q[1] ? quo_fix : prod_fix[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MULT;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // A cancel arriving in the DONE cycle must still squash the write.
  always_comb begin
    busy       = (state_q == CALC);
    HILO_Write = ((state_q == DONE) && !cancel) ? 2'b11 : 2'b00;
    HI_in      = hi_q;
    LO_in      = lo_q;
  end

endmodule
